// File: rtl/decode_unit_core.sv
// Purpose: decode stage; registers opcode/imm/rd/operands/branch target from one 16-bit instr per cycle.
// Latency: 1 cycle from instr to outputs; register-file write is visible to reads from the next cycle.
// Backpressure: stall holds every output; is_branch_taken overrides stall and loads a NOP bubble.
//
// Ports: clk, reset (async active-low), stall, is_branch_taken, instr[15:0] from fetch,
//        wb_en/wb_addr/wb_data from write-back, registered opcode/imm/rd/op1/op2/branch_target.
// Optional feature macro: WB_BYPASS_EN (forward wb_data into same-cycle operand reads).
module decode_unit_core #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_branch_taken,
    input  logic [15:0]       instr,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [3:0]        opcode,
    output logic [4:0]        imm,
    output logic [2:0]        rd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] branch_target
);

    // Instruction fields
    logic [3:0] f_opcode;
    logic       f_imm_flag;
    logic [2:0] f_rd;
    logic [2:0] f_rs1;
    logic [2:0] f_rs2;
    logic [4:0] f_imm5;

    assign f_opcode   = instr[15:12];
    assign f_imm_flag = instr[11];
    assign f_rd       = instr[10:8];
    assign f_rs1      = instr[7:5];
    assign f_imm5     = instr[4:0];
    assign f_rs2      = instr[2:0];

    // Register file; entry 0 is never written and is masked to zero on read.
    logic [DATA_W-1:0] regs [0:7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    always_comb begin
        rs1_val = (f_rs1 == 3'd0) ? '0 : regs[f_rs1];
        rs2_val = (f_rs2 == 3'd0) ? '0 : regs[f_rs2];
`ifdef WB_BYPASS_EN
        // Forward the in-flight write so a same-cycle reader sees the new value.
        if (wb_en && (wb_addr != 3'd0) && (wb_addr == f_rs1)) begin
            rs1_val = wb_data;
        end
        if (wb_en && (wb_addr != 3'd0) && (wb_addr == f_rs2)) begin
            rs2_val = wb_data;
        end
`endif
    end

    // Combinational decode of the current instr
    logic              is_branch;
    logic [DATA_W-1:0] d_op2;
    logic [DATA_W-1:0] d_target;

    assign is_branch = (f_opcode[3:2] == 2'b11);

    always_comb begin
        d_op2 = f_imm_flag ? {{(DATA_W-5){1'b0}}, f_imm5} : rs2_val;
        // Target wraps modulo 2^DATA_W; non-branch opcodes report zero.
        d_target = is_branch ? (rs1_val + {{(DATA_W-5){f_imm5[4]}}, f_imm5}) : '0;
    end

    // Output register: flush beats stall, stall holds, otherwise load the decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode        <= '0;
            imm           <= '0;
            rd            <= '0;
            op1           <= '0;
            op2           <= '0;
            branch_target <= '0;
        end else if (is_branch_taken) begin
            opcode        <= '0;
            imm           <= '0;
            rd            <= '0;
            op1           <= '0;
            op2           <= '0;
            branch_target <= '0;
        end else if (!stall) begin
            opcode        <= f_opcode;
            imm           <= f_imm5;
            rd            <= f_rd;
            op1           <= rs1_val;
            op2           <= d_op2;
            branch_target <= d_target;
        end
    end

endmodule

// File: tb/tb_decode_unit_core.sv
// Purpose: self-checking bench for decode_unit_core using an expected-result queue.
// Latency: each step drives on the falling edge and compares 1 ns after the next rising edge.
// Backpressure: stall/flush expectations come from the bench's own hold/bubble model.
module tb_decode_unit_core;

    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              is_branch_taken;
    logic [15:0]       instr;
    logic              wb_en;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        opcode;
    logic [4:0]        imm;
    logic [2:0]        rd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] branch_target;

    decode_unit_core #(.DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .is_branch_taken (is_branch_taken),
        .instr           (instr),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .opcode          (opcode),
        .imm             (imm),
        .rd              (rd),
        .op1             (op1),
        .op2             (op2),
        .branch_target   (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [4:0]  imm;
        logic [2:0]  rd;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] bt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_exp;
    logic [15:0] m_regs [0:7];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".opcode"}, {12'h0, opcode}, {12'h0, e.opcode});
        check({tag, ".imm"},    {11'h0, imm},    {11'h0, e.imm});
        check({tag, ".rd"},     {13'h0, rd},     {13'h0, e.rd});
        check({tag, ".op1"},    op1,             e.op1);
        check({tag, ".op2"},    op2,             e.op2);
        check({tag, ".bt"},     branch_target,   e.bt);
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] idx, input logic we,
                                               input logic [2:0] wa, input logic [15:0] wd);
        logic [15:0] v;
        v = (idx == 3'd0) ? 16'h0 : m_regs[idx];
`ifdef WB_BYPASS_EN
        if (we && wa != 3'd0 && wa == idx) v = wd;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        last_exp = '0;
    endtask

    // One clock of stimulus: drive, push expectation, update model, compare after the edge.
    task automatic step(input string tag, input logic [15:0] i, input logic s, input logic f,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd);
        exp_t e;
        exp_t got;
        logic [15:0] v1;
        @(negedge clk);
        instr = i; stall = s; is_branch_taken = f;
        wb_en = we; wb_addr = wa; wb_data = wd;
        if (f) begin
            e = '0;
        end else if (s) begin
            e = last_exp;
        end else begin
            v1 = model_read(i[7:5], we, wa, wd);
            e.opcode = i[15:12];
            e.imm    = i[4:0];
            e.rd     = i[10:8];
            e.op1    = v1;
            e.op2    = i[11] ? {11'h0, i[4:0]} : model_read(i[2:0], we, wa, wd);
            e.bt     = (i[15:14] == 2'b11) ? v1 + {{11{i[4]}}, i[4:0]} : 16'h0;
        end
        sb_q.push_back(e);
        last_exp = e;
        if (we && wa != 3'd0) m_regs[wa] = wd;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_all(tag, got);
        wb_en = 1'b0;
    endtask

    initial begin
        exp_t zero_e;
        zero_e = '0;
        reset = 1'b0; stall = 1'b0; is_branch_taken = 1'b0;
        instr = 16'h0; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        model_reset();
        #3;
        check_all("reset", zero_e);
        @(negedge clk);
        reset = 1'b1;

        step("nop", 16'h0000, 0, 0, 0, 3'd0, 16'h0);
        step("wr_r3", 16'h0000, 0, 0, 1, 3'd3, 16'h0010);
        step("imm", 16'h1871, 0, 0, 0, 3'd0, 16'h0);
        check("imm.op2_lit", op2, 16'h0011);
        check("imm.op1_lit", op1, 16'h0010);

        step("wr_r5", 16'h0000, 0, 0, 1, 3'd5, 16'h1234);
        step("wr_r2", 16'h0000, 0, 0, 1, 3'd2, 16'h00FF);
        step("reg", 16'h21A2, 0, 0, 0, 3'd0, 16'h0);
        check("reg.op1_lit", op1, 16'h1234);
        check("reg.op2_lit", op2, 16'h00FF);

        step("branch", 16'hC87E, 0, 0, 0, 3'd0, 16'h0);
        check("branch.bt_lit", branch_target, 16'h000E);
        step("wr_r3_0", 16'h0000, 0, 0, 1, 3'd3, 16'h0000);
        step("branch_wrap", 16'hC87E, 0, 0, 0, 3'd0, 16'h0);
        check("branch_wrap.bt_lit", branch_target, 16'hFFFE);

        step("flush", 16'h21A2, 0, 1, 0, 3'd0, 16'h0);
        step("stall_zero", 16'h21A2, 1, 0, 0, 3'd0, 16'h0);
        step("stall_flush", 16'h21A2, 1, 1, 0, 3'd0, 16'h0);
        step("resume", 16'h21A2, 0, 0, 0, 3'd0, 16'h0);
        step("stall_hold", 16'h1871, 1, 0, 0, 3'd0, 16'h0);
        check("stall_hold.op1_lit", op1, 16'h1234);

        step("bypass", 16'h21A2, 0, 0, 1, 3'd5, 16'hBEEF);
`ifdef WB_BYPASS_EN
        check("bypass.op1_lit", op1, 16'hBEEF);
`else
        check("bypass.op1_lit", op1, 16'h1234);
`endif
        step("after_wr", 16'h21A2, 0, 0, 0, 3'd0, 16'h0);
        check("after_wr.op1_lit", op1, 16'hBEEF);

        step("r0_bypass", 16'h2000, 0, 0, 1, 3'd0, 16'hFFFF);
        step("r0_read", 16'h2000, 0, 0, 0, 3'd0, 16'h0);
        check("r0_read.op1_lit", op1, 16'h0000);

        // Mid-operation asynchronous reset, applied away from any rising edge.
        step("pre_rst", 16'h21A2, 0, 0, 0, 3'd0, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst", zero_e);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 16'h21A2, 0, 0, 0, 3'd0, 16'h0);
        check("post_rst.op1_lit", op1, 16'h0000);

        if (sb_q.size() != 0) begin
            n_err++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
